data_memory_dump: RTL

//  Data-memory responder for the pipelined LEGv8 core: services the MEM-stage store/load port and owns the doubleword array.
//  On a dump request it walks the array and streams every word (address + data) out over a valid/ready port.
//  The bench and the on-board debug path use this stream to check final memory state.

---
 rtl/data_memory_dump_if.sv | 28 ++
 rtl/data_memory_dump.sv | 124 ++++++++++++
 2 files changed

// File: rtl/data_memory_dump_if.sv
// Memory-port and dump-stream bundle between the MEM stage / debug consumer and data_memory_dump.
interface data_memory_dump_if #(
    parameter int N         = 64,
    parameter int ADDR_BITS = 5
);
    logic                 memWrite;
    logic                 memRead;
    logic [N-1:0]         address;
    logic [N-1:0]         writeData;
    logic [N-1:0]         readData;
    logic                 dump;
    logic                 dump_valid;
    logic                 dump_ready;
    logic [ADDR_BITS-1:0] dump_addr;
    logic [N-1:0]         dump_data;
    logic                 dump_done;
    logic                 busy;

    modport master (
        output memWrite, memRead, address, writeData, dump, dump_ready,
        input  readData, dump_valid, dump_addr, dump_data, dump_done, busy
    );

    modport slave (
        input  memWrite, memRead, address, writeData, dump, dump_ready,
        output readData, dump_valid, dump_addr, dump_data, dump_done, busy
    );
endinterface

// File: rtl/data_memory_dump.sv
// LEGv8 data memory with a valid/ready dump stream of the whole doubleword array.
// Define DUMP_SKIP_ZERO_EN to leave zero words out of the dump stream.
module data_memory_dump #(
    parameter int N         = 64,
    parameter int DEPTH     = 32,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input logic               CLOCK_50,
    input logic               reset,
    data_memory_dump_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a rising edge on dump
    // SCAN  | walking the array, ptr is the next index to fetch
    // DONE  | one-cycle dump_done pulse, back to IDLE
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam int PTR_BITS = ADDR_BITS + 1;

    state_t               state_q, state_d;
    logic [N-1:0]         mem_q [DEPTH];
    logic [N-1:0]         mem_d [DEPTH];
    logic [PTR_BITS-1:0]  ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [N-1:0]         data_q, data_d;
    logic                 dump_prev_q, dump_prev_d;

    logic [ADDR_BITS-1:0] idx;
    logic [ADDR_BITS-1:0] fetch_idx;
    logic                 in_range;
    logic                 skip_word;
    logic                 unused_addr_lsbs;

    assign idx              = bus.address[ADDR_BITS+2:3];
    assign in_range         = (bus.address[N-1:ADDR_BITS+3] == '0);
    assign unused_addr_lsbs = ^bus.address[2:0];
    assign fetch_idx        = ptr_q[ADDR_BITS-1:0];

    // Array read is combinational, so a same-cycle store is only seen next cycle.
    assign bus.readData   = (bus.memRead && in_range) ? mem_q[idx] : '0;
    assign bus.dump_valid = valid_q;
    assign bus.dump_addr  = addr_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_done  = (state_q == DONE);
    assign bus.busy       = (state_q == SCAN);

`ifdef DUMP_SKIP_ZERO_EN
    assign skip_word = (mem_q[fetch_idx] == '0);
`else
    assign skip_word = 1'b0;
`endif

    always_comb begin
        mem_d = mem_q;
        if (bus.memWrite && in_range) begin
            mem_d[idx] = bus.writeData;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        dump_prev_d = bus.dump;
        case (state_q)
            IDLE: begin
                if (bus.dump && !dump_prev_q) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                end
            end
            SCAN: begin
                // Output slot is free when empty or its word is taken this cycle.
                if (!valid_q || bus.dump_ready) begin
                    valid_d = 1'b0;
                    if (ptr_q >= PTR_BITS'(DEPTH)) begin
                        state_d = DONE;
                    end else if (skip_word) begin
                        ptr_d = ptr_q + 1'b1;
                        if (ptr_q == PTR_BITS'(DEPTH - 1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = fetch_idx;
                        data_d  = mem_q[fetch_idx];
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            dump_prev_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dump_prev_q <= dump_prev_d;
            mem_q       <= mem_d;
        end
    end
endmodule
